sha1_msg_padder: RTL and testbench
==================================

Name: sha1_msg_padder

Overview:
- Upstream stage of the SHA-1 compression core. Accepts a message as a byte stream and packs it into 512-bit blocks.
- Appends the SHA-1 padding: a 0x80 byte, zero bytes, then the 64-bit big-endian message bit length.
- Presents each block on a valid/ready interface, flagging the final block of each message.
- Emits one or two extra padding blocks' worth of work as required by the message length.

Parameters:
- LEN_W, 64: width of the internal bit-length counter. Zero-extended to 64 bits when written into the length field. The counter wraps modulo 2^LEN_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low; clears all state immediately.
- in_valid  in  1  input byte qualifier.
- in_ready  out  1  padder can accept a byte; high only in FILL.
- in_data  in  8  message byte, in message order.
- in_last  in  1  with in_valid: this transfer ends the message.
- in_nobyte  in  1  with in_valid & in_last: terminate without writing in_data. This is how an empty message is sent, or a message ending on an already-sent byte.
- out_block  out  512  packed block. Word i (i = 0..15) occupies bits [32i+31:32i]. Word 0 is the first four message bytes. The earliest byte of each word sits in bits [31:24].
- out_valid  out  1  out_block is complete and stable.
- out_ready  in  1  consumer accepts out_block.
- out_last  out  1  with out_valid: this is the final block of the message (its length field is populated).

Behaviour:
- Reset (rst=0): state=FILL, ptr=0, bit_len=0, buffer all zero, pad_pending=0, len_pending=0, final=0. out_valid=0, out_last=0, out_block=0, in_ready=1 once rst is released.
- A reset mid-message or mid-handoff discards everything. No partial block is ever emitted afterwards.
- Buffer: 64 bytes. It is cleared to zero on every out handshake (out_valid & out_ready), so all padding zeros are implicit.

State FILL:
- in_ready=1. On in_valid & in_ready & !(in_last & in_nobyte): write in_data at byte ptr, ptr<=ptr+1, bit_len<=bit_len+8.
- Next state:
  - If the byte was written at ptr=63 and in_last=1: set pad_pending, go to OUT.
  - If the byte was written at ptr=63 and in_last=0: go to OUT.
  - Else if in_last=1: go to PAD.
- On in_last & in_nobyte: no write, go to PAD.

State PAD (1 cycle):
- Write 0x80 at ptr.
- If ptr<=55: go to LEN.
- Else: set len_pending, go to OUT (non-final block).

State LEN (1 cycle):
- Write bit_len (64-bit, big-endian) into bytes 56..63, i.e. word14 = bits[63:32] and word15 = bits[31:0].
- Set final, go to OUT.

State OUT:
- out_valid=1, out_last=final. out_block must be held stable until the handshake.
- On the handshake: clear buffer, ptr<=0. Then:
  - if final: clear final and bit_len, go to FILL;
  - else if pad_pending: clear it, go to PAD;
  - else if len_pending: clear it, go to LEN;
  - else go to FILL.

Timing and invariants:
- out_valid is registered and rises on the cycle after the state enters OUT.
- Latency for an N-byte message with N<=55: N accept cycles + PAD + LEN, then out_valid on the next edge.
- out_valid must not drop without a handshake.
- in_ready=0 in PAD, LEN and OUT. in_data is ignored whenever in_ready=0.
- A message of exactly 64k bytes produces k data blocks plus one block of 0x80…length.
- A message with length mod 64 in 56..63 produces a block containing 0x80, then a zero block carrying only the length.

Decomposition:
- Shared package sha1_pkg holds:
  - BLOCK_W=512, WORD_W=32;
  - PAD_BYTE=8'h80, LEN_OFFSET=56;
  - the state encoding (FILL, PAD, LEN, OUT);
  - the SHA-1 initial H values, also used by the core.
- No sub-module. The byte-write-into-buffer logic is a single indexed write; no separate block is warranted.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) -> one block:
  - word0=0x61626380, words1..14=0, word15=0x00000018;
  - out_last=1; out_valid exactly 6 cycles after the first accept.
- Empty message (in_valid, in_last, in_nobyte) -> word0=0x80000000, all other words 0, out_last=1.
- 56 bytes of 0x00 -> block 1: bytes 0..55=0, byte56=0x80, rest 0, out_last=0. Block 2: words0..14=0, word15=0x000001C0, out_last=1.
- 64 bytes 0x00..0x3F -> block 1 is raw data (word0=0x00010203), out_last=0. Block 2: word0=0x80000000, word15=0x00000200, out_last=1.
- out_ready held low 10 cycles in OUT, with in_valid toggling -> out_block stable, in_ready=0, no bytes lost. The next message is accepted correctly after the handshake.
- rst pulsed low after 20 bytes of a message -> out_valid=0 and in_ready=1 after release. A following "abc" yields exactly the block from the first scenario.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: block geometry, padding constants, padder state encoding and
// the initial hash values used by the compression core.
package sha1_pkg;

  localparam int unsigned BLOCK_W    = 512;
  localparam int unsigned WORD_W     = 32;
  localparam logic [7:0]  PAD_BYTE   = 8'h80;
  localparam int unsigned LEN_OFFSET = 56;

  typedef enum logic [1:0] {
    StFill,
    StPad,
    StLen,
    StOut
  } pad_state_e;

  localparam logic [31:0] SHA1_H0 = 32'h67452301;
  localparam logic [31:0] SHA1_H1 = 32'hEFCDAB89;
  localparam logic [31:0] SHA1_H2 = 32'h98BADCFE;
  localparam logic [31:0] SHA1_H3 = 32'h10325476;
  localparam logic [31:0] SHA1_H4 = 32'hC3D2E1F0;

endpackage

// File: rtl/sha1_msg_padder.sv
// Packs a byte stream into 512-bit SHA-1 blocks, appending 0x80, zero fill and the
// big-endian message bit length, and hands blocks out over valid/ready.
module sha1_msg_padder
  import sha1_pkg::*;
#(
  parameter int unsigned LenW = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [7:0]         in_data_i,
  input  logic               in_last_i,
  input  logic               in_nobyte_i,
  output logic [BLOCK_W-1:0] out_block_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_last_o
);

  localparam int unsigned NumBytes = BLOCK_W / 8;
  localparam logic [5:0]  LenByte0 = 6'(LEN_OFFSET);

  pad_state_e      state_q;
  logic [5:0]      ptr_q;
  logic [LenW-1:0] bit_len_q;
  logic [7:0]      buf_q [NumBytes];
  logic            pad_pending_q;
  logic            len_pending_q;
  logic            final_q;
  logic            out_valid_q;
  logic            out_last_q;
  logic [63:0]     len64;

  assign len64       = 64'(bit_len_q);
  assign in_ready_o  = (state_q == StFill);
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;

  // Byte k lands in word k/4, earliest byte of each word in the top lane.
  always_comb begin
    out_block_o = '0;
    for (int k = 0; k < NumBytes; k++) begin
      out_block_o[WORD_W*(k/4) + 8*(3 - k%4) +: 8] = buf_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StFill;
      ptr_q         <= '0;
      bit_len_q     <= '0;
      pad_pending_q <= 1'b0;
      len_pending_q <= 1'b0;
      final_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      for (int i = 0; i < NumBytes; i++) buf_q[i] <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (in_valid_i) begin
            if (in_last_i && in_nobyte_i) begin
              state_q <= StPad;
            end else begin
              buf_q[ptr_q] <= in_data_i;
              ptr_q        <= ptr_q + 6'd1;
              bit_len_q    <= bit_len_q + LenW'(8);
              if (ptr_q == 6'd63) begin
                // A full block closing the message still owes a padding block.
                pad_pending_q <= in_last_i;
                state_q       <= StOut;
              end else if (in_last_i) begin
                state_q <= StPad;
              end
            end
          end
        end
        StPad: begin
          buf_q[ptr_q] <= PAD_BYTE;
          if (32'(ptr_q) < LEN_OFFSET) begin
            state_q <= StLen;
          end else begin
            len_pending_q <= 1'b1;
            state_q       <= StOut;
          end
        end
        StLen: begin
          for (int i = 0; i < 8; i++) buf_q[LenByte0 + 6'(i)] <= len64[63-8*i -: 8];
          final_q <= 1'b1;
          state_q <= StOut;
        end
        StOut: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_last_q  <= final_q;
          end else if (out_ready_i) begin
            for (int i = 0; i < NumBytes; i++) buf_q[i] <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (final_q) begin
              final_q   <= 1'b0;
              bit_len_q <= '0;
              state_q   <= StFill;
            end else if (pad_pending_q) begin
              pad_pending_q <= 1'b0;
              state_q       <= StPad;
            end else if (len_pending_q) begin
              len_pending_q <= 1'b0;
              state_q       <= StLen;
            end else begin
              state_q <= StFill;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed bench for sha1_msg_padder: hand-computed blocks for short, empty, boundary-length,
// full-block, back-pressured and reset-interrupted messages.
module tb_sha1_msg_padder;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_nobyte;
  logic [511:0] out_block;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  sha1_msg_padder dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .in_nobyte_i(in_nobyte),
    .out_block_o(out_block),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_last_o (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Presents one byte from a negedge; returns the cycle count at which it was presented.
  task automatic send_byte(input logic [7:0] d, input logic last, input logic nobyte,
                           output int drv_cyc);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    drv_cyc = cyc;
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end else begin
      in_valid  = 1'b1;
      in_data   = d;
      in_last   = last;
      in_nobyte = nobyte;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_nobyte = 1'b0;
    end
  endtask

  task automatic wait_valid(output int seen_cyc);
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    seen_cyc = cyc;
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL recv_timeout: out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic recv_block(output logic [511:0] blk, output logic last, output int seen_cyc);
    wait_valid(seen_cyc);
    blk  = out_block;
    last = out_last;
    if (out_valid) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic send_abc(output int first_cyc);
    int c;
    send_byte(8'h61, 1'b0, 1'b0, first_cyc);
    send_byte(8'h62, 1'b0, 1'b0, c);
    send_byte(8'h63, 1'b1, 1'b0, c);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #23;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    total++;
    if (out_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_last: got %b want 0", out_last);
    end
    total++;
    if (out_block !== 512'h0) begin
      bad++;
      $display("FAIL reset_out_block: got %h want 0", out_block);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_abc;
    logic [511:0] exp, blk;
    logic         last;
    int           c0, cv;
    exp            = '0;
    exp[31:0]      = 32'h61626380;
    exp[511:480]   = 32'h00000018;
    send_abc(c0);
    recv_block(blk, last, cv);
    total++;
    if (blk !== exp) begin
      bad++;
      $display("FAIL abc_block: got %h want %h", blk, exp);
    end
    total++;
    if (last !== 1'b1) begin
      bad++;
      $display("FAIL abc_last: got %b want 1", last);
    end
    // 3 accept cycles, PAD, LEN, OUT entry: out_valid first seen 6 cycles after the first accept.
    total++;
    if (cv - c0 != 6) begin
      bad++;
      $display("FAIL abc_latency: got %0d cycles want 6", cv - c0);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abc_after_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_empty;
    logic [511:0] exp, blk;
    logic         last;
    int           c;
    exp       = '0;
    exp[31:0] = 32'h80000000;
    send_byte(8'hA5, 1'b1, 1'b1, c);
    recv_block(blk, last, c);
    total++;
    if (blk !== exp || last !== 1'b1) begin
      bad++;
      $display("FAIL empty_block: got %h last=%b want %h last=1", blk, last, exp);
    end
  endtask

  task automatic test_56_zero;
    logic [511:0] exp1, exp2, blk;
    logic         last;
    int           c;
    exp1            = '0;
    exp1[479:448]   = 32'h80000000;
    exp2            = '0;
    exp2[511:480]   = 32'h000001C0;
    for (int i = 0; i < 56; i++) send_byte(8'h00, (i == 55), 1'b0, c);
    recv_block(blk, last, c);
    total++;
    if (blk !== exp1 || last !== 1'b0) begin
      bad++;
      $display("FAIL z56_block1: got %h last=%b want %h last=0", blk, last, exp1);
    end
    recv_block(blk, last, c);
    total++;
    if (blk !== exp2 || last !== 1'b1) begin
      bad++;
      $display("FAIL z56_block2: got %h last=%b want %h last=1", blk, last, exp2);
    end
  endtask

  task automatic test_64_seq;
    logic [511:0] exp1, exp2, blk;
    logic [7:0]   b;
    logic         last;
    int           c;
    exp1 = '0;
    for (int w = 0; w < 16; w++) begin
      b = 8'(4 * w);
      exp1[32*w +: 32] = {b, b + 8'd1, b + 8'd2, b + 8'd3};
    end
    exp2          = '0;
    exp2[31:0]    = 32'h80000000;
    exp2[511:480] = 32'h00000200;
    for (int i = 0; i < 64; i++) send_byte(8'(i), (i == 63), 1'b0, c);
    recv_block(blk, last, c);
    total++;
    if (blk[31:0] !== 32'h00010203) begin
      bad++;
      $display("FAIL seq64_word0: got %h want 00010203", blk[31:0]);
    end
    total++;
    if (blk !== exp1 || last !== 1'b0) begin
      bad++;
      $display("FAIL seq64_block1: got %h last=%b want %h last=0", blk, last, exp1);
    end
    recv_block(blk, last, c);
    total++;
    if (blk !== exp2 || last !== 1'b1) begin
      bad++;
      $display("FAIL seq64_block2: got %h last=%b want %h last=1", blk, last, exp2);
    end
  endtask

  task automatic test_back_to_back;
    logic [511:0] exp, exp2, held, blk;
    logic         last;
    int           c;
    exp          = '0;
    exp[31:0]    = 32'h61626380;
    exp[511:480] = 32'h00000018;
    exp2          = '0;
    exp2[31:0]    = 32'h64658000;
    exp2[511:480] = 32'h00000010;
    send_abc(c);
    wait_valid(c);
    held = out_block;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      in_data  = 8'hEE;
      in_last  = in_valid;
      @(negedge clk);
      total++;
      if (out_block !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_%0d: valid=%b ready=%b block=%h want valid=1 ready=0 block=%h",
                 i, out_valid, in_ready, out_block, held);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++;
    if (held !== exp) begin
      bad++;
      $display("FAIL stall_block: got %h want %h", held, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_byte(8'h64, 1'b0, 1'b0, c);
    send_byte(8'h65, 1'b1, 1'b0, c);
    recv_block(blk, last, c);
    total++;
    if (blk !== exp2 || last !== 1'b1) begin
      bad++;
      $display("FAIL next_msg_block: got %h last=%b want %h last=1", blk, last, exp2);
    end
  endtask

  task automatic test_reset_mid;
    logic [511:0] exp, blk;
    logic         last;
    int           c;
    exp          = '0;
    exp[31:0]    = 32'h61626380;
    exp[511:480] = 32'h00000018;
    for (int i = 0; i < 20; i++) send_byte(8'hC3, 1'b0, 1'b0, c);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_block !== 512'h0) begin
      bad++;
      $display("FAIL midrst_clear: got %h want 0", out_block);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    send_abc(c);
    recv_block(blk, last, c);
    total++;
    if (blk !== exp || last !== 1'b1) begin
      bad++;
      $display("FAIL midrst_abc: got %h last=%b want %h last=1", blk, last, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    in_nobyte = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_abc();
    test_empty();
    test_56_zero();
    test_64_seq();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
